ws2811_transmitter: RTL and testbench
=====================================

# ws2811_transmitter

Serial line driver for the WS2811 LED chain. It walks `ledindex` from 0 to NUM_LEDS-1 and fetches each LED's colour from `ledcontroller`, whose outputs are registered one clock after `ledindex`. It serialises each colour as 24 NRZ-pulse bits on `dout`, then holds the line low for the latch/reset interval. It sits between `ledcontroller` and the strip's data pin.

## Interface
- NUM_LEDS, 49: LEDs per frame, 1..256.
- TBIT, 15: clocks per bit period (1.25 µs at 12 MHz).
- T0H, 4: clocks `dout` stays high for a 0 bit.
- T1H, 8: clocks `dout` stays high for a 1 bit. Constraint: 0 < T0H < T1H < TBIT.
- TRESET, 600: clocks `dout` stays low after the last LED (50 µs at 12 MHz).
- clk  in  1  system clock. One clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; start frames and keep repeating them while high.
- red, green, blue  in  8 each  colour for the presented `ledindex`, valid two edges after `ledindex` changes.
- ledindex  out  8  LED whose colour is being fetched.
- dout  out  1  registered serial data to the strip.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on the last cycle of LATCH.

## Operation
- Reset values: `dout`=0, `ledindex`=0, `busy`=0, `frame_done`=0, state IDLE, all counters 0.
- States: IDLE, FETCH, SEND, LATCH.
- IDLE → FETCH when `enable`=1. `ledindex` is 0.
- FETCH lasts exactly 2 cycles; `dout`=0.
  - At the end of FETCH, {green, red, blue} loads into a 24-bit shift register (GRB order, MSB first).
  - Bit count and LED count clear. State → SEND.
- SEND, per bit, with bit timer t = 0..TBIT-1:
  - `dout`=1 for t < (bit ? T1H : T0H), else 0.
- SEND prefetch:
  - On the first cycle of bit 0 of LED n, `ledindex` ← n+1 if n < NUM_LEDS-1.
  - The colour is therefore settled long before bit 23 ends.
- End of bit 23 of LED n (t = TBIT-1):
  - n < NUM_LEDS-1: load the next colour into the shift register, n ← n+1, continue SEND with no gap. Bit pitch is exactly TBIT across LED boundaries.
  - n = NUM_LEDS-1: `ledindex` ← 0, state → LATCH.
- LATCH: `dout`=0 for TRESET cycles. `frame_done`=1 on the final cycle, then:
  - `enable`=1: → FETCH.
  - `enable`=0: → IDLE.
- Deasserting `enable` mid-frame does not truncate the frame. The current frame completes with its full LATCH, then the block idles.
- `rst` mid-frame: next edge enters the reset values. `dout` is forced low at once, so the partial frame is never latched as valid by the strip until a full TRESET has passed.
- Colour inputs are sampled only at shift-register load edges. Changes at other times are ignored.
- Counter widths:
  - bit timer: clog2(TBIT)
  - bit count: 5 bits, 0..23
  - LED count: 8 bits
  - reset timer: clog2(TRESET)
- No counter wraps except by explicit reload.

## Timing
- `enable` sampled high in IDLE at edge e: FETCH covers e+1 and e+2. `dout` rises at edge e+3 for the first bit (registered output).
- Frame length from the first `dout` rise to the `frame_done` cycle inclusive: 24·TBIT·NUM_LEDS + TRESET cycles.
- Frame-to-frame repeat period under continuous `enable`: 2 + 24·TBIT·NUM_LEDS + TRESET.
- Colour capture point: `ledindex` changes at edge k; `red`/`green`/`blue` are sampled at edge ≥ k+2. Prefetch guarantees ≥ 23·TBIT cycles of margin.
- NUM_LEDS=1: no prefetch increment occurs, and `ledindex` stays 0 throughout.

## Structure
- Package `ws2811_pkg`:
  - state enum {IDLE, FETCH, SEND, LATCH}
  - BITS_PER_LED=24
  - FETCH_CYCLES=2
  - default timing constants for 12 MHz
- Sub-module `ws2811_bit_timer`:
  - inputs: `clk`, `rst`, `start`, `bit`
  - outputs: `pulse` (the high/low waveform for one bit) and `last` (high at t = TBIT-1)
  - parameterised by TBIT/T0H/T1H
- The top level holds the FSM, the shift register, the LED counter and the reset timer.

## Test plan
- Two-LED colour stream:
  - Setup: NUM_LEDS=2, stub controller with one-cycle registered output; LED0 = R 0xFF, G 0x00, B 0x0F; LED1 = R 0x00, G 0x80, B 0x01.
  - Required: decoded bits are 0x00FF0F then 0x800001, high widths only 4 or 8 cycles, every rise spaced exactly 15 cycles.
- Frame timing and repeat (NUM_LEDS=49, `enable` held high):
  - First `dout` rise at e+3.
  - `frame_done` pulses 17640+600-1 cycles after the first rise.
  - Next rise 3 cycles after the `frame_done` cycle.
  - `ledindex` sequence is 0,1,…,48,0.
- Enable drop mid-frame: drop `enable` during LED 10. Required: all 49 LEDs are sent, LATCH runs its full 600 cycles, then `busy`=0 and `dout` stays 0.
- Reset mid-frame: assert `rst` for 1 cycle during bit 5 of LED 3. Required: next cycle `dout`=0, `ledindex`=0, `busy`=0; restarting gives a clean frame starting at LED 0.
- Capture timing: stub changes colours at non-load edges. Required: only the values present at load edges appear on the wire.
- NUM_LEDS=1, colour 0xFFFFFF: 24 pulses of 8-cycle width, `ledindex` constant 0, then 600 low cycles.

Source files
------------

// File: rtl/ws2811_pkg.sv
// Shared types and default timing for the WS2811 serial line driver.
package ws2811_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  localparam int BITS_PER_LED = 24;
  localparam int FETCH_CYCLES = 2;

  // Defaults for a 12 MHz system clock.
  localparam int DEF_NUM_LEDS = 49;
  localparam int DEF_TBIT     = 15;   // 1.25 us bit period
  localparam int DEF_T0H      = 4;    // high time of a 0 bit
  localparam int DEF_T1H      = 8;    // high time of a 1 bit
  localparam int DEF_TRESET   = 600;  // 50 us latch interval

endpackage

// File: rtl/ws2811_bit_timer.sv
// One WS2811 bit period: a registered high/low pulse plus an end-of-bit flag.
// A start on the last cycle of a bit chains the next bit with no gap.
module ws2811_bit_timer
  import ws2811_pkg::*;
#(
  parameter int TBIT = DEF_TBIT,
  parameter int T0H  = DEF_T0H,
  parameter int T1H  = DEF_T1H
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic data_bit,
  output logic pulse,
  output logic last
);

  localparam int TW = $clog2(TBIT);
  localparam logic [TW-1:0] T_LAST = TW'(TBIT - 1);

  logic [TW-1:0] t;
  logic          active;
  logic          bit_q;

  function automatic int high_len(input logic b);
    return b ? T1H : T0H;
  endfunction

  // Bit timer: pulse is the waveform value for the current t, so it is high on t = 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      pulse  <= 1'b0;
      bit_q  <= 1'b0;
      t      <= '0;
    end else if (start) begin
      active <= 1'b1;
      pulse  <= 1'b1;
      bit_q  <= data_bit;
      t      <= '0;
    end else if (active) begin
      if (t == T_LAST) begin
        active <= 1'b0;
        pulse  <= 1'b0;
        t      <= '0;
      end else begin
        t     <= t + 1'b1;
        pulse <= (int'(t) + 1 < high_len(bit_q));
      end
    end
  end

  assign last = active && (t == T_LAST);

endmodule

// File: rtl/ws2811_transmitter.sv
// WS2811 frame sequencer: fetches each LED colour by index, streams it as
// 24 GRB bits MSB first, then holds the line low for the latch interval.
module ws2811_transmitter
  import ws2811_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int TBIT     = DEF_TBIT,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int TRESET   = DEF_TRESET
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic [7:0] ledindex,
  output logic       dout,
  output logic       busy,
  output logic       frame_done
);

  localparam int RW = (TRESET > 1) ? $clog2(TRESET) : 1;
  localparam logic [7:0]    LAST_LED = 8'(NUM_LEDS - 1);
  localparam logic [4:0]    LAST_BIT = 5'(BITS_PER_LED - 1);
  localparam logic [1:0]    LAST_FET = 2'(FETCH_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(TRESET - 1);
  localparam logic [RW-1:0] RST_PRE  = RW'(TRESET - 2);

  state_t        state;
  logic          enable_q;
  logic [1:0]    fetch_cnt;
  logic [4:0]    bit_cnt;
  logic [7:0]    led_cnt;
  logic [RW-1:0] rst_cnt;
  logic          prefetch;
  logic [23:0]   shift;

  logic pulse, last, start, data_bit;
  logic load_first, bit_end, led_end, frame_end;

  // Event decode shared by the FSM, the shift register and the bit timer.
  always_comb begin
    load_first = (state == FETCH) && (fetch_cnt == LAST_FET);
    bit_end    = (state == SEND) && last;
    led_end    = bit_end && (bit_cnt == LAST_BIT);
    frame_end  = led_end && (led_cnt == LAST_LED);
    start      = load_first || (bit_end && !frame_end);
    // On a colour load the MSB goes straight to the timer; otherwise the
    // shift register head is the next bit to send.
    data_bit   = (load_first || led_end) ? green[7] : shift[23];
  end

  // Frame FSM with LED/bit/latch counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      enable_q   <= 1'b0;
      fetch_cnt  <= '0;
      bit_cnt    <= '0;
      led_cnt    <= '0;
      rst_cnt    <= '0;
      prefetch   <= 1'b0;
      ledindex   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      enable_q   <= enable;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_q) begin
            state     <= FETCH;
            busy      <= 1'b1;
            fetch_cnt <= '0;
            ledindex  <= '0;
          end
        end
        FETCH: begin
          fetch_cnt <= fetch_cnt + 2'd1;
          if (load_first) begin
            state    <= SEND;
            bit_cnt  <= '0;
            led_cnt  <= '0;
            prefetch <= 1'b1;
          end
        end
        SEND: begin
          // Advance the index one cycle into each LED so the controller's
          // registered colour is settled long before the next load.
          if (prefetch) begin
            prefetch <= 1'b0;
            if (led_cnt != LAST_LED) ledindex <= led_cnt + 8'd1;
          end
          if (led_end) begin
            bit_cnt <= '0;
            if (frame_end) begin
              state      <= LATCH;
              ledindex   <= '0;
              rst_cnt    <= '0;
              frame_done <= (TRESET == 1);
            end else begin
              led_cnt  <= led_cnt + 8'd1;
              prefetch <= 1'b1;
            end
          end else if (bit_end) begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        LATCH: begin
          if (rst_cnt == RST_LAST) begin
            state     <= enable ? FETCH : IDLE;
            busy      <= enable;
            fetch_cnt <= '0;
          end else begin
            rst_cnt    <= rst_cnt + 1'b1;
            frame_done <= (rst_cnt == RST_PRE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Colour shift register: holds the bits not yet handed to the bit timer.
  always_ff @(posedge clk) begin
    if (load_first || (led_end && !frame_end)) shift <= {green[6:0], red, blue, 1'b0};
    else if (bit_end)                          shift <= {shift[22:0], 1'b0};
  end

  ws2811_bit_timer #(
    .TBIT (TBIT),
    .T0H  (T0H),
    .T1H  (T1H)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_bit (data_bit),
    .pulse    (pulse),
    .last     (last)
  );

  assign dout = pulse;

endmodule

// File: tb/tb_ws2811_transmitter.sv
// Directed bench for ws2811_transmitter: three instances (2, 49 and 1 LEDs)
// with registered colour stubs; a negedge monitor records the line activity.
module tb_ws2811_transmitter;

  localparam int TBIT    = 15;
  localparam int T0H     = 4;
  localparam int T1H     = 8;
  localparam int TRESET  = 600;
  localparam int LED_CYC = 24 * TBIT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic rst;
  logic en2, en49, en1;
  logic [23:0] noise2;
  logic [7:0]  idx2, idx49, idx1;
  logic [23:0] rgb2_q, rgb49_q, rgb1_q;   // {r, g, b}
  logic [23:0] col2;
  logic dout2, busy2, fd2, dout49, busy49, fd49, dout1, busy1, fd1;

  function automatic logic [23:0] tab2(input logic [7:0] i);
    return (i == 8'd0) ? 24'hFF000F : 24'h008001;
  endfunction

  function automatic logic [23:0] tab49(input logic [7:0] i);
    return {i, ~i, i ^ 8'h3C};
  endfunction

  function automatic logic [23:0] grb49(input int i);
    logic [7:0] v;
    v = 8'(i);
    return {~v, v, v ^ 8'h3C};
  endfunction

  // Controller stubs: colour registered one clock after ledindex.
  always @(posedge clk) begin
    rgb2_q  <= tab2(idx2);
    rgb49_q <= tab49(idx49);
    rgb1_q  <= 24'hFFFFFF;
  end

  assign col2 = rgb2_q ^ noise2;

  ws2811_transmitter #(.NUM_LEDS(2), .TBIT(TBIT), .T0H(T0H), .T1H(T1H), .TRESET(TRESET)) dut2 (
    .clk(clk), .rst(rst), .enable(en2),
    .red(col2[23:16]), .green(col2[15:8]), .blue(col2[7:0]),
    .ledindex(idx2), .dout(dout2), .busy(busy2), .frame_done(fd2));

  ws2811_transmitter #(.NUM_LEDS(49), .TBIT(TBIT), .T0H(T0H), .T1H(T1H), .TRESET(TRESET)) dut49 (
    .clk(clk), .rst(rst), .enable(en49),
    .red(rgb49_q[23:16]), .green(rgb49_q[15:8]), .blue(rgb49_q[7:0]),
    .ledindex(idx49), .dout(dout49), .busy(busy49), .frame_done(fd49));

  ws2811_transmitter #(.NUM_LEDS(1), .TBIT(TBIT), .T0H(T0H), .T1H(T1H), .TRESET(TRESET)) dut1 (
    .clk(clk), .rst(rst), .enable(en1),
    .red(rgb1_q[23:16]), .green(rgb1_q[15:8]), .blue(rgb1_q[7:0]),
    .ledindex(idx1), .dout(dout1), .busy(busy1), .frame_done(fd1));

  // Monitor selection and recording
  logic [1:0] sel;
  logic       m_dout, m_fd;
  logic [7:0] m_idx;
  assign m_dout = (sel == 2'd0) ? dout2 : (sel == 2'd1) ? dout49 : dout1;
  assign m_fd   = (sel == 2'd0) ? fd2   : (sel == 2'd1) ? fd49   : fd1;
  assign m_idx  = (sel == 2'd0) ? idx2  : (sel == 2'd1) ? idx49  : idx1;

  int rise_q[$];
  int width_q[$];
  int fd_q[$];
  int idx_q[$];
  logic d_last = 1'b0;
  int run = 0;
  logic [7:0] idx_last = 8'd0;

  always @(negedge clk) begin
    if (m_dout && !d_last) begin
      rise_q.push_back(cyc);
      run = 1;
    end else if (m_dout) begin
      run++;
    end
    if (!m_dout && d_last) width_q.push_back(run);
    if (m_idx != idx_last) idx_q.push_back(int'(m_idx));
    idx_last = m_idx;
    if (m_fd) fd_q.push_back(cyc);
    d_last = m_dout;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic clear_mon();
    rise_q.delete();
    width_q.delete();
    fd_q.delete();
    idx_q.delete();
  endtask

  function automatic int rq(input int i);
    return (i < rise_q.size()) ? rise_q[i] : -1;
  endfunction

  function automatic int fq(input int i);
    return (i < fd_q.size()) ? fd_q[i] : -1;
  endfunction

  task automatic wait_fd(input int n, input int limit, input string tag);
    int k;
    k = 0;
    while (fd_q.size() < n && k < limit) begin
      step();
      k++;
    end
    check_val(tag, 32'(fd_q.size() >= n), 32'd1);
  endtask

  task automatic decode(input int led, output logic [23:0] w);
    w = '0;
    for (int b = 0; b < 24; b++) begin
      int i;
      i = led * 24 + b;
      w = {w[22:0], (i < width_q.size()) ? (width_q[i] == T1H) : 1'bx};
    end
  endtask

  task automatic pulse_stats(input int first, input int n, output int bad_w, output int bad_p);
    bad_w = 0;
    bad_p = 0;
    for (int i = first; i < first + n; i++) begin
      if (i >= width_q.size() || (width_q[i] != T0H && width_q[i] != T1H)) bad_w++;
      if (i > first && (i >= rise_q.size() || rise_q[i] - rise_q[i-1] != TBIT)) bad_p++;
    end
  endtask

  initial begin
    logic [23:0] w;
    int c, r0, r2, rc, bw, bp, bad;

    rst = 1'b1; en2 = 1'b0; en49 = 1'b0; en1 = 1'b0; noise2 = '0; sel = 2'd0;
    steps(3);
    check_val("rst_outs2",  32'({dout2,  busy2,  fd2,  idx2}),  32'd0);
    check_val("rst_outs49", 32'({dout49, busy49, fd49, idx49}), 32'd0);
    check_val("rst_outs1",  32'({dout1,  busy1,  fd1,  idx1}),  32'd0);
    rst = 1'b0;
    steps(2);

    // Two-LED colour stream
    sel = 2'd0; clear_mon();
    c = cyc; en2 = 1'b1;
    steps(5); en2 = 1'b0;
    wait_fd(1, 3000, "t1_frame_done_seen");
    step();
    r0 = rq(0);
    check_val("t1_first_rise", r0, c + 4);
    check_val("t1_npulses", rise_q.size(), 48);
    decode(0, w); check_val("t1_led0", 32'(w), 32'h00FF0F);
    decode(1, w); check_val("t1_led1", 32'(w), 32'h800001);
    pulse_stats(0, 48, bw, bp);
    check_val("t1_widths", bw, 0);
    check_val("t1_pitch", bp, 0);
    check_val("t1_frame_done", fq(0), r0 + 2 * LED_CYC + TRESET - 1);
    check_val("t1_idle", 32'({busy2, dout2}), 32'd0);

    // Capture timing: colours are garbage except around the two load edges
    clear_mon();
    c = cyc; en2 = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if (cyc == c + 5) en2 = 1'b0;
      noise2 = (cyc == c + 3 || cyc == c + 3 + LED_CYC) ? 24'h0 : 24'($urandom_range(1, 24'hFFFFFF));
      step();
    end
    noise2 = '0;
    check_val("t2_frames", fd_q.size(), 1);
    check_val("t2_npulses", rise_q.size(), 48);
    decode(0, w); check_val("t2_led0", 32'(w), 32'h00FF0F);
    decode(1, w); check_val("t2_led1", 32'(w), 32'h800001);

    // 49-LED frame timing, repeat, then enable drop during LED 10 of frame 2
    sel = 2'd1; clear_mon();
    c = cyc; en49 = 1'b1;
    wait_fd(1, 20000, "t3_frame1_done_seen");
    r0 = rq(0);
    check_val("t3_first_rise", r0, c + 4);
    check_val("t3_frame_done", fq(0), r0 + 49 * LED_CYC + TRESET - 1);
    check_val("t3_idx_count", idx_q.size(), 49);
    bad = 0;
    for (int i = 0; i < 49; i++)
      if (i >= idx_q.size() || idx_q[i] != ((i < 48) ? i + 1 : 0)) bad++;
    check_val("t3_idx_seq", bad, 0);
    decode(0, w);  check_val("t3_led0", 32'(w), 32'hFF003C);
    decode(48, w); check_val("t3_led48", 32'(w), 32'hCF300C);
    bad = 0;
    for (int i = 0; i < 49; i++) begin
      decode(i, w);
      if (w !== grb49(i)) bad++;
    end
    check_val("t3_all_leds", bad, 0);
    pulse_stats(0, 49 * 24, bw, bp);
    check_val("t3_widths", bw, 0);
    check_val("t3_pitch", bp, 0);
    for (int k = 0; k < 10 && rise_q.size() <= 49 * 24; k++) step();
    r2 = rq(49 * 24);
    check_val("t3_repeat_rise", r2, fq(0) + 3);
    while (cyc < r2 + 10 * LED_CYC + 50) step();
    en49 = 1'b0;
    wait_fd(2, 20000, "t3_frame2_done_seen");
    check_val("t3_frame2_done", fq(1), r2 + 49 * LED_CYC + TRESET - 1);
    check_val("t3_frame2_pulses", rise_q.size(), 2 * 49 * 24);
    step();
    check_val("t3_busy_low", 32'(busy49), 32'd0);
    steps(40);
    check_val("t3_stays_idle", 32'({busy49, dout49}), 32'd0);
    check_val("t3_no_new_rise", rise_q.size(), 2 * 49 * 24);

    // Reset during bit 5 of LED 3, then a clean restart
    clear_mon();
    c = cyc; en49 = 1'b1;
    while (cyc < c + 4 + 3 * LED_CYC + 5 * TBIT + 2) step();
    check_val("t4_pre_busy", 32'({busy49, dout49}), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rc = cyc;
    check_val("t4_after_rst", 32'({dout49, busy49, idx49}), 32'd0);
    clear_mon();
    steps(2 * LED_CYC + 20);
    check_val("t4_restart_rise", rq(0), rc + 4);
    decode(0, w); check_val("t4_restart_led0", 32'(w), 32'hFF003C);
    decode(1, w); check_val("t4_restart_led1", 32'(w), 32'hFE013D);
    en49 = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_val("t4_stopped", 32'({busy49, dout49}), 32'd0);

    // Single LED, all ones
    sel = 2'd2; clear_mon();
    c = cyc; en1 = 1'b1;
    steps(5); en1 = 1'b0;
    wait_fd(1, 3000, "t5_frame_done_seen");
    step();
    r0 = rq(0);
    check_val("t5_first_rise", r0, c + 4);
    check_val("t5_npulses", rise_q.size(), 24);
    decode(0, w); check_val("t5_word", 32'(w), 32'hFFFFFF);
    bad = 0;
    for (int i = 0; i < width_q.size(); i++) if (width_q[i] != T1H) bad++;
    check_val("t5_widths", bad, 0);
    pulse_stats(0, 24, bw, bp);
    check_val("t5_pitch", bp, 0);
    check_val("t5_idx_const", idx_q.size(), 0);
    check_val("t5_latch_len", fq(0) - (rq(23) + TBIT) + 1, TRESET);
    check_val("t5_idle", 32'({busy1, dout1, idx1}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
